alu_74181_nibble_seq: RTL and testbench

- Controller that runs one 4-bit alu_74181 slice serially to perform a wide (4*NIBBLES-bit) logic or arithmetic operation, one nibble per clock, LSB nibble first.
- Accepts one operation per request over a valid/ready handshake.
- For each nibble, drives the slice's S, M, carry-in, A and B inputs, then captures F, carry-out and A=B.
- Returns the assembled result and flags over a second valid/ready handshake.
- Sits between the instruction decode logic and the single shared alu_74181 instance.

---
 rtl/alu_74181_pkg.sv | 30 +++
 rtl/alu_74181_nibble_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_74181_nibble_seq.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_74181_pkg.sv
// ---------------------------------------------------------------------------
// alu_74181_pkg
// Shared definitions for the serial 74181 nibble controller:
//   NIBBLE_W     width of one 74181 slice
//   seq_state_t  controller states (IDLE, EXEC, DONE)
//   ALU_S_*      named 74181 S codes for common operations
//   ALU_M_*      74181 mode control values
// ---------------------------------------------------------------------------
package alu_74181_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // SUB and XOR share one S code; M selects between them.
    localparam logic [3:0] ALU_S_ADD    = 4'b1001;
    localparam logic [3:0] ALU_S_SUB    = 4'b0110;
    localparam logic [3:0] ALU_S_XOR    = 4'b0110;
    localparam logic [3:0] ALU_S_AND    = 4'b1011;
    localparam logic [3:0] ALU_S_OR     = 4'b1110;
    localparam logic [3:0] ALU_S_PASS_A = 4'b1111;

    localparam logic ALU_M_LOGIC = 1'b1;
    localparam logic ALU_M_ARITH = 1'b0;

endpackage

// File: rtl/alu_74181_nibble_seq.sv
// ---------------------------------------------------------------------------
// alu_74181_nibble_seq
// Runs one shared 4-bit 74181 slice serially over a 4*NIBBLES-bit operation,
// one nibble per clock, least significant nibble first.
//
// Ports
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   op_select_i, op_mode_i    74181 S code and M bit for the operation
//   carry_in_i                active-high carry into nibble 0
//   A_i, B_i                  wide operands
//   alu_S_o .. alu_B_o        drive to the shared slice (zero outside EXEC)
//   alu_F_i, alu_cn4_i,
//   alu_eq_i                  results returned by the slice
//   rsp_valid_o/rsp_ready_i   response handshake
//   result_o                  assembled F
//   carry_out_o               carry out of the last nibble
//   equal_o                   AND of the slice A=B output over all nibbles
//   zero_o                    result_o == 0
//   busy_o                    controller not idle
// ---------------------------------------------------------------------------
module alu_74181_nibble_seq
    import alu_74181_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [3:0]                  op_select_i,
    input  logic                        op_mode_i,
    input  logic                        carry_in_i,
    input  logic [NIBBLE_W*NIBBLES-1:0] A_i,
    input  logic [NIBBLE_W*NIBBLES-1:0] B_i,

    output logic [3:0]                  alu_S_o,
    output logic                        alu_M_o,
    output logic                        alu_cn_o,
    output logic [NIBBLE_W-1:0]         alu_A_o,
    output logic [NIBBLE_W-1:0]         alu_B_o,
    input  logic [NIBBLE_W-1:0]         alu_F_i,
    input  logic                        alu_cn4_i,
    input  logic                        alu_eq_i,

    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [NIBBLE_W*NIBBLES-1:0] result_o,
    output logic                        carry_out_o,
    output logic                        equal_o,
    output logic                        zero_o,
    output logic                        busy_o
);

    localparam int W  = NIBBLE_W * NIBBLES;
    // Nibble index width; a single-nibble build still gets a 1-bit counter.
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    seq_state_t      state_reg;
    logic [3:0]      s_reg;
    logic            m_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    result_reg;
    logic            carry_reg;
    logic            eq_reg;
    logic [KW-1:0]   k_reg;
    logic            req_ready_reg;
    logic            rsp_valid_reg;
    logic            busy_reg;

    // Per-nibble views of the latched operands and per-nibble result write
    // enables, so the slice mux and the result store are plain array indexing.
    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLES-1:0]  nib_we;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi]  = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi]  = b_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign nib_we[gi] = (state_reg == EXEC) && (k_reg == KW'(gi));
        end
    endgenerate

    // Slice drive: only meaningful in EXEC, held at zero otherwise so the
    // shared slice sees quiet inputs while the controller is idle or waiting.
    always_comb begin
        alu_S_o  = '0;
        alu_M_o  = 1'b0;
        alu_cn_o = 1'b0;
        alu_A_o  = '0;
        alu_B_o  = '0;
        if (state_reg == EXEC) begin
            alu_S_o  = s_reg;
            alu_M_o  = m_reg;
            alu_cn_o = carry_reg;
            alu_A_o  = a_nib[k_reg];
            alu_B_o  = b_nib[k_reg];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            m_reg         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            eq_reg        <= 1'b0;
            k_reg         <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Result nibble k is captured straight from the slice; unknowns
            // on alu_F_i are stored as they are.
            for (int i = 0; i < NIBBLES; i++) begin
                if (nib_we[i]) begin
                    result_reg[i*NIBBLE_W +: NIBBLE_W] <= alu_F_i;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (req_valid_i && req_ready_reg) begin
                        state_reg     <= EXEC;
                        s_reg         <= op_select_i;
                        m_reg         <= op_mode_i;
                        a_reg         <= A_i;
                        b_reg         <= B_i;
                        carry_reg     <= carry_in_i;
                        eq_reg        <= 1'b1;
                        k_reg         <= '0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end

                EXEC: begin
                    // The carry register doubles as the ripple link between
                    // nibbles and, after the last one, as the final carry out.
                    carry_reg <= alu_cn4_i;
                    eq_reg    <= eq_reg & alu_eq_i;
                    if (k_reg == K_LAST) begin
                        state_reg     <= DONE;
                        k_reg         <= '0;
                        rsp_valid_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end

                DONE: begin
                    // Requests are not taken here even when the response is
                    // consumed; the controller passes through IDLE first.
                    if (rsp_ready_i) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign busy_o      = busy_reg;
    assign result_o    = result_reg;
    assign carry_out_o = carry_reg;
    assign equal_o     = eq_reg;
    assign zero_o      = (result_reg == '0);

endmodule

// File: tb/tb_alu_74181_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_74181_nibble_seq
// Drives the controller with directed operations while a behavioural 74181
// answers on the alu_* ports. A wide arithmetic reference predicts every
// response; a per-cycle compare process checks slice drive, handshakes and
// results against it; directed literals pin the expected values.
// ---------------------------------------------------------------------------
module tb_alu_74181_nibble_seq;
    import alu_74181_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [3:0]   op_select_i;
    logic         op_mode_i;
    logic         carry_in_i;
    logic [W-1:0] A_i;
    logic [W-1:0] B_i;
    logic [3:0]   alu_S_o;
    logic         alu_M_o;
    logic         alu_cn_o;
    logic [3:0]   alu_A_o;
    logic [3:0]   alu_B_o;
    logic [3:0]   alu_F_i;
    logic         alu_cn4_i;
    logic         alu_eq_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] result_o;
    logic         carry_out_o;
    logic         equal_o;
    logic         zero_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    alu_74181_nibble_seq #(.NIBBLES(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_select_i (op_select_i),
        .op_mode_i   (op_mode_i),
        .carry_in_i  (carry_in_i),
        .A_i         (A_i),
        .B_i         (B_i),
        .alu_S_o     (alu_S_o),
        .alu_M_o     (alu_M_o),
        .alu_cn_o    (alu_cn_o),
        .alu_A_o     (alu_A_o),
        .alu_B_o     (alu_B_o),
        .alu_F_i     (alu_F_i),
        .alu_cn4_i   (alu_cn4_i),
        .alu_eq_i    (alu_eq_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .carry_out_o (carry_out_o),
        .equal_o     (equal_o),
        .zero_o      (zero_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // 74181 logic functions (active-high data), bitwise so valid at any width.
    function automatic logic [W-1:0] logic_fn(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return '0;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return '1;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    // Arithmetic addends: the 74181 arithmetic result is x + y + carry.
    function automatic logic [W-1:0] add_x(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        return a | (s[0] ? b : '0) | (s[1] ? ~b : '0);
    endfunction
    function automatic logic [W-1:0] add_y(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        return (s[2] ? (a & ~b) : '0) | (s[3] ? (a & b) : '0);
    endfunction

    // Whole-operand reference: {carry_out, result}.
    function automatic logic [W:0] wide_ref(input logic [3:0] s, input logic m, input logic c,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        if (m) return {1'b0, logic_fn(s, a, b)};
        return {1'b0, add_x(s, a, b)} + {1'b0, add_y(s, a, b)} + {{W{1'b0}}, c};
    endfunction

    // Carry that must enter nibble k in arithmetic mode.
    function automatic logic carry_into(input logic [3:0] s, input logic c,
                                        input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        logic [W-1:0] mask;
        logic [W:0]   sum;
        if (k == 0) return c;
        mask = (W'(1) << (4 * k)) - W'(1);
        sum  = {1'b0, add_x(s, a, b) & mask} + {1'b0, add_y(s, a, b) & mask} + {{W{1'b0}}, c};
        return sum[4 * k];
    endfunction

    // Single-slice behavioural 74181: {A=B, cn4, F}.
    function automatic logic [5:0] f181(input logic [3:0] s, input logic m, input logic c,
                                        input logic [3:0] a, input logic [3:0] b);
        logic [3:0]   x, y, f;
        logic [4:0]   sum;
        logic [W-1:0] lw;
        logic         co;
        co = 1'b0;
        if (m) begin
            lw = logic_fn(s, {{(W-4){1'b0}}, a}, {{(W-4){1'b0}}, b});
            f  = lw[3:0];
        end else begin
            x   = a | (s[0] ? b : 4'h0) | (s[1] ? ~b : 4'h0);
            y   = (s[2] ? (a & ~b) : 4'h0) | (s[3] ? (a & b) : 4'h0);
            sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
            f   = sum[3:0];
            co  = sum[4];
        end
        return {(f == 4'hF), co, f};
    endfunction

    always_comb begin
        {alu_eq_i, alu_cn4_i, alu_F_i} = f181(alu_S_o, alu_M_o, alu_cn_o, alu_A_o, alu_B_o);
    end

    // ---------------- reference model of the transaction timeline ----------
    int           cyc = 0;
    int           t_acc = 0;
    logic         in_flight = 1'b0;
    logic         reset_seen = 1'b0;
    logic [3:0]   m_s;
    logic         m_m;
    logic         m_c;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W:0]   m_ref;

    always @(posedge clk) begin
        if (rst_i) begin
            in_flight  <= 1'b0;
            reset_seen <= 1'b1;
        end else if (!in_flight) begin
            if (req_valid_i) begin
                in_flight <= 1'b1;
                t_acc     <= cyc;
                m_s       <= op_select_i;
                m_m       <= op_mode_i;
                m_c       <= carry_in_i;
                m_a       <= A_i;
                m_b       <= B_i;
                m_ref     <= wide_ref(op_select_i, op_mode_i, carry_in_i, A_i, B_i);
            end
        end else if ((cyc - t_acc >= N + 1) && rsp_ready_i) begin
            in_flight <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int t_rel;
        int k;
        if (reset_seen) begin
            if (!in_flight) begin
                chk("idle_busy", 32'(busy_o), 32'd0);
                chk("idle_req_ready", 32'(req_ready_o), 32'd1);
                chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
                chk("idle_slice", 32'({alu_S_o, alu_M_o, alu_cn_o, alu_A_o, alu_B_o}), 32'd0);
            end else begin
                t_rel = cyc - t_acc;
                if (t_rel <= N) begin
                    k = t_rel - 1;
                    chk("exec_busy", 32'(busy_o), 32'd1);
                    chk("exec_req_ready", 32'(req_ready_o), 32'd0);
                    chk("exec_rsp_valid", 32'(rsp_valid_o), 32'd0);
                    chk("exec_S", 32'(alu_S_o), 32'(m_s));
                    chk("exec_M", 32'(alu_M_o), 32'(m_m));
                    chk("exec_A", 32'(alu_A_o), 32'(m_a[4*k +: 4]));
                    chk("exec_B", 32'(alu_B_o), 32'(m_b[4*k +: 4]));
                    if (!m_m) chk("exec_cn", 32'(alu_cn_o), 32'(carry_into(m_s, m_c, m_a, m_b, k)));
                end else begin
                    chk("done_rsp_valid", 32'(rsp_valid_o), 32'd1);
                    chk("done_busy", 32'(busy_o), 32'd1);
                    chk("done_req_ready", 32'(req_ready_o), 32'd0);
                    chk("done_slice", 32'({alu_S_o, alu_M_o, alu_cn_o, alu_A_o, alu_B_o}), 32'd0);
                    chk("done_result", 32'(result_o), 32'(m_ref[W-1:0]));
                    chk("done_zero", 32'(zero_o), 32'(m_ref[W-1:0] == '0));
                    chk("done_equal", 32'(equal_o), 32'(m_ref[W-1:0] == '1));
                    if (!m_m) chk("done_carry", 32'(carry_out_o), 32'(m_ref[W]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at a falling edge with the controller idle; returns at a falling
    // edge with the controller idle again.
    task automatic do_op(input logic [3:0] s, input logic m, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input logic pulse,
                         input logic [W-1:0] exp_res, input logic exp_cout, input logic exp_eq);
        int lat;
        req_valid_i = 1'b1;
        op_select_i = s;
        op_mode_i   = m;
        carry_in_i  = c;
        A_i         = a;
        B_i         = b;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(N + 1));
        chk("lit_result", 32'(result_o), 32'(exp_res));
        chk("lit_zero", 32'(zero_o), 32'(exp_res == '0));
        chk("lit_equal", 32'(equal_o), 32'(exp_eq));
        if (!m) chk("lit_carry", 32'(carry_out_o), 32'(exp_cout));
        $display("op S=%b M=%b cin=%b A=%h B=%h -> result=%h cout=%b eq=%b zero=%b lat=%0d",
                 s, m, c, a, b, result_o, carry_out_o, equal_o, zero_o, lat);
        for (int d = 0; d < hold; d++) begin
            if (pulse && d == 1) begin
                req_valid_i = 1'b1;
                A_i         = ~a;
            end
            @(negedge clk);
            req_valid_i = 1'b0;
            chk("hold_result", 32'(result_o), 32'(exp_res));
            chk("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_req_ready", 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("release_req_ready", 32'(req_ready_o), 32'd1);
        chk("release_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        op_select_i = '0;
        op_mode_i   = 1'b0;
        carry_in_i  = 1'b0;
        A_i         = '0;
        B_i         = '0;

        // Pin the reference model itself with hand-computed values.
        chk("pin_f181_add", 32'(f181(ALU_S_ADD, ALU_M_ARITH, 1'b1, 4'hF, 4'h0)), 32'h10);
        chk("pin_f181_xor", 32'(f181(ALU_S_XOR, ALU_M_LOGIC, 1'b0, 4'hA, 4'h5)), 32'h2F);
        chk("pin_wide_sub", 32'(wide_ref(ALU_S_SUB, ALU_M_ARITH, 1'b1, 16'h1234, 16'h0234)), 32'h11000);
        chk("pin_wide_xor", 32'(wide_ref(ALU_S_XOR, ALU_M_LOGIC, 1'b0, 16'hA5A5, 16'hFFFF)), 32'h05A5A);
        chk("pin_carry_into", 32'(carry_into(ALU_S_ADD, 1'b0, 16'h0FFF, 16'h0001, 3)), 32'd1);

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_flags", 32'({carry_out_o, equal_o, zero_o}), 32'b001);
        rst_i = 1'b0;
        @(negedge clk);

        do_op(ALU_S_ADD, ALU_M_ARITH, 1'b0, 16'h0FFF, 16'h0001, 0, 1'b0, 16'h1000, 1'b0, 1'b0);
        do_op(ALU_S_ADD, ALU_M_ARITH, 1'b0, 16'hFFFF, 16'h0001, 0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(ALU_S_SUB, ALU_M_ARITH, 1'b1, 16'h1234, 16'h0234, 0, 1'b0, 16'h1000, 1'b1, 1'b0);
        do_op(ALU_S_SUB, ALU_M_ARITH, 1'b0, 16'h3C3C, 16'h3C3C, 0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        do_op(ALU_S_XOR, ALU_M_LOGIC, 1'b0, 16'hA5A5, 16'hFFFF, 3, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        do_op(ALU_S_AND, ALU_M_LOGIC, 1'b1, 16'hF0F0, 16'h3C3C, 0, 1'b0, 16'h3030, 1'b0, 1'b0);
        do_op(ALU_S_OR,  ALU_M_LOGIC, 1'b0, 16'hF0F0, 16'h0F0F, 2, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        do_op(ALU_S_PASS_A, ALU_M_LOGIC, 1'b0, 16'h8001, 16'h7777, 0, 1'b0, 16'h8001, 1'b0, 1'b0);

        // Reset in the middle of an operation, after two nibbles.
        req_valid_i = 1'b1;
        op_select_i = ALU_S_ADD;
        op_mode_i   = ALU_M_ARITH;
        carry_in_i  = 1'b1;
        A_i         = 16'h1111;
        B_i         = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midrst_result", 32'(result_o), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_o), 32'd1);
        $display("reset mid-op: busy=%b rsp_valid=%b result=%h req_ready=%b",
                 busy_o, rsp_valid_o, result_o, req_ready_o);
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (12) @(negedge clk);
        rsp_ready_i = 1'b0;

        // Back-to-back operation after the reset still works.
        do_op(ALU_S_ADD, ALU_M_ARITH, 1'b1, 16'h00FF, 16'h0F00, 0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
